// File: rtl/cail_sched.sv
// cail_sched: issue scheduler for the shared short->float->multiply calibration datapath.
// Takes one frame of NUM_CH samples, issues one sample per cycle with its channel's
// coefficient, and tags every slot so results can be re-associated at the pipeline output.
// Optional feature macro: CAIL_PARAM_WR_EN adds param_wr/param_addr/param_wdata and a
// writable coefficient file; without it every coefficient is the constant 1.0.
// Handshake: frame_valid is a one-cycle strobe with no back-pressure. A frame is always
// accepted into the work buffer (IDLE) or the pending buffer; if both are occupied and no
// promotion frees pending in that cycle, the new frame is dropped and overflow pulses.
module cail_sched #(
   parameter  int NUM_CH   = 8,
   parameter  int PIPE_LAT = 9,
   localparam int CH_W     = $clog2(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_valid,
   input  logic [16*NUM_CH-1:0] frame_data,
   input  logic [NUM_CH-1:0]    ch_mask,
`ifdef CAIL_PARAM_WR_EN
   input  logic                 param_wr,
   input  logic [CH_W-1:0]      param_addr,
   input  logic [31:0]          param_wdata,
`endif
   output logic [15:0]          dp_data,
   output logic [31:0]          dp_param,
   input  logic [31:0]          dp_result,
   output logic                 res_valid,
   output logic [CH_W-1:0]      res_ch,
   output logic [31:0]          res_data,
   output logic                 frame_done,
   output logic                 busy,
   output logic                 overflow,
   output logic [1:0]           dbg_state
);

   localparam logic [31:0]     COEF_ONE = 32'h3F80_0000;
   localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

   // occ marks a slot that was issued (masked or not); vld marks a slot that yields a result.
   typedef struct packed {
      logic            occ;
      logic            vld;
      logic            last;
      logic [CH_W-1:0] ch;
   } tag_t;

   state_t               state_q, state_d;
   logic [CH_W-1:0]      idx_q, idx_d;
   logic [16*NUM_CH-1:0] work_q, work_d, pend_q, pend_d;
   logic [NUM_CH-1:0]    wmask_q, wmask_d, pmask_q, pmask_d;
   logic                 pend_full_q, pend_full_d;
   // Entry 0 travels with the dp_data/dp_param registers; entries 1..PIPE_LAT follow the
   // datapath latency, so the head lines up with dp_result.
   tag_t                 tag_q [PIPE_LAT+1];
   tag_t                 tag_in_d, head;
   logic [15:0]          dp_data_q, dp_data_d;
   logic [31:0]          dp_param_q, dp_param_d, coef_rd;
   logic                 res_valid_q, res_valid_d;
   logic                 frame_done_q, frame_done_d;
   logic                 overflow_q, overflow_d;
   logic [CH_W-1:0]      res_ch_q, res_ch_d;
   logic [31:0]          res_data_q, res_data_d;
   logic                 pipe_occ, promote, load_new, issue;

`ifdef CAIL_PARAM_WR_EN
   logic [31:0] coef_q [NUM_CH];

   // Coefficient file: a write lands at the edge, so the slot issued in that cycle sees the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) coef_q[i] <= COEF_ONE;
      end else if (param_wr) begin
         coef_q[param_addr] <= param_wdata;
      end
   end

   assign coef_rd = coef_q[idx_q];
`else
   assign coef_rd = COEF_ONE;
`endif

   assign head = tag_q[PIPE_LAT];

   // Any issued slot still in flight keeps the scheduler out of IDLE.
   always_comb begin
      pipe_occ = 1'b0;
      for (int i = 0; i <= PIPE_LAT; i++) pipe_occ = pipe_occ | tag_q[i].occ;
   end

   // FSM next state, issue datapath and input arbitration between work and pending buffers.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      work_d      = work_q;
      wmask_d     = wmask_q;
      pend_d      = pend_q;
      pmask_d     = pmask_q;
      pend_full_d = pend_full_q;
      tag_in_d    = '0;
      dp_data_d   = '0;
      dp_param_d  = '0;
      overflow_d  = 1'b0;
      promote     = 1'b0;
      load_new    = 1'b0;
      issue       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pend_full_q) begin
               promote = 1'b1;
               idx_d   = '0;
               state_d = S_ISSUE;
            end else if (frame_valid) begin
               load_new = 1'b1;
               idx_d    = '0;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            issue = 1'b1;
            idx_d = idx_q + CH_W'(1);
            if (idx_q == LAST_CH) begin
               if (pend_full_q) begin
                  // Back-to-back frame: next cycle issues slot 0 of the promoted frame.
                  promote = 1'b1;
                  idx_d   = '0;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pend_full_q) begin
               promote = 1'b1;
               idx_d   = '0;
               state_d = S_ISSUE;
            end else if (!pipe_occ) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (issue) begin
         dp_data_d     = wmask_q[idx_q] ? work_q[16*idx_q +: 16] : 16'h0000;
         dp_param_d    = coef_rd;
         tag_in_d.occ  = 1'b1;
         tag_in_d.vld  = wmask_q[idx_q];
         tag_in_d.last = (idx_q == LAST_CH);
         tag_in_d.ch   = idx_q;
      end

      if (promote) begin
         work_d      = pend_q;
         wmask_d     = pmask_q;
         pend_full_d = 1'b0;
      end

      if (load_new) begin
         work_d  = frame_data;
         wmask_d = ch_mask;
      end

      // A promotion in the same cycle frees pending, so the new frame is kept rather than dropped.
      if (frame_valid && !load_new) begin
         if (!pend_full_q || promote) begin
            pend_d      = frame_data;
            pmask_d     = ch_mask;
            pend_full_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   // Result side: re-associate the datapath product with the tag at the head of the pipe.
   always_comb begin
      res_valid_d  = head.occ & head.vld;
      frame_done_d = head.occ & head.last;
      res_ch_d     = head.ch;
      res_data_d   = (head.occ & head.vld) ? dp_result : 32'h0;
   end

   // State, buffers, tag pipe and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         work_q       <= '0;
         wmask_q      <= '0;
         pend_q       <= '0;
         pmask_q      <= '0;
         pend_full_q  <= 1'b0;
         dp_data_q    <= '0;
         dp_param_q   <= '0;
         res_valid_q  <= 1'b0;
         res_ch_q     <= '0;
         res_data_q   <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         for (int i = 0; i <= PIPE_LAT; i++) tag_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         work_q       <= work_d;
         wmask_q      <= wmask_d;
         pend_q       <= pend_d;
         pmask_q      <= pmask_d;
         pend_full_q  <= pend_full_d;
         dp_data_q    <= dp_data_d;
         dp_param_q   <= dp_param_d;
         res_valid_q  <= res_valid_d;
         res_ch_q     <= res_ch_d;
         res_data_q   <= res_data_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         tag_q[0]     <= tag_in_d;
         for (int i = 1; i <= PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign dp_data    = dp_data_q;
   assign dp_param   = dp_param_q;
   assign res_valid  = res_valid_q;
   assign res_ch     = res_ch_q;
   assign res_data   = res_data_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign busy       = (state_q != S_IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_cail_sched.sv
// tb_cail_sched: directed bench for cail_sched with a behavioural float-multiply datapath.
// Coefficient-write scenarios are present only when CAIL_PARAM_WR_EN is defined.
module tb_cail_sched;

   localparam int NUM_CH   = 8;
   localparam int PIPE_LAT = 9;
   localparam int EW       = 45;   // {rel[7:0], frame_done, res_valid, ch[2:0], data[31:0]}

   logic         clk = 1'b0;
   logic         rst;
   logic         frame_valid;
   logic [127:0] frame_data;
   logic [7:0]   ch_mask;
`ifdef CAIL_PARAM_WR_EN
   logic         param_wr;
   logic [2:0]   param_addr;
   logic [31:0]  param_wdata;
`endif
   logic [15:0]  dp_data;
   logic [31:0]  dp_param;
   logic [31:0]  dp_result;
   logic         res_valid;
   logic [2:0]   res_ch;
   logic [31:0]  res_data;
   logic         frame_done;
   logic         busy;
   logic         overflow;
   logic [1:0]   dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // clock / reset ---------------------------------------------------------
   always #5 clk = ~clk;

   cail_sched #(.NUM_CH(NUM_CH), .PIPE_LAT(PIPE_LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .ch_mask     (ch_mask),
`ifdef CAIL_PARAM_WR_EN
      .param_wr    (param_wr),
      .param_addr  (param_addr),
      .param_wdata (param_wdata),
`endif
      .dp_data     (dp_data),
      .dp_param    (dp_param),
      .dp_result   (dp_result),
      .res_valid   (res_valid),
      .res_ch      (res_ch),
      .res_data    (res_data),
      .frame_done  (frame_done),
      .busy        (busy),
      .overflow    (overflow),
      .dbg_state   (dbg_state)
   );

   // behavioural datapath: float(dp_data) * dp_param, PIPE_LAT cycles later -------
   function automatic real f32_to_real(input logic [31:0] f);
      logic [63:0] b;
      logic [10:0] e;
      if (f[30:0] == 31'h0) return 0.0;
      e = 11'(f[30:23]) - 11'd127 + 11'd1023;
      b = {f[31], e, f[22:0], 29'h0};
      return $bitstoreal(b);
   endfunction

   function automatic logic [31:0] real_to_f32(input real r);
      logic [63:0] b;
      logic [10:0] e;
      logic [10:0] e8;
      if (r == 0.0) return 32'h0;
      b  = $realtobits(r);
      e  = b[62:52];
      e8 = e - 11'd1023 + 11'd127;
      return {b[63], e8[7:0], b[51:29]};
   endfunction

   logic [31:0] dp_pipe [PIPE_LAT];
   always @(posedge clk) begin
      dp_pipe[0] <= real_to_f32($itor($signed(dp_data)) * f32_to_real(dp_param));
      for (int i = 1; i < PIPE_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
   end
   assign dp_result = dp_pipe[PIPE_LAT-1];

   // hand-computed IEEE-754 single values of 0..15
   function automatic logic [31:0] fval(input int k);
      case (k)
         0:  return 32'h0000_0000;  1:  return 32'h3F80_0000;
         2:  return 32'h4000_0000;  3:  return 32'h4040_0000;
         4:  return 32'h4080_0000;  5:  return 32'h40A0_0000;
         6:  return 32'h40C0_0000;  7:  return 32'h40E0_0000;
         8:  return 32'h4100_0000;  9:  return 32'h4110_0000;
         10: return 32'h4120_0000;  11: return 32'h4130_0000;
         12: return 32'h4140_0000;  13: return 32'h4150_0000;
         14: return 32'h4160_0000;  15: return 32'h4170_0000;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic logic [EW-1:0] mk(input int rel, input logic fd, input logic v,
                                        input logic [2:0] ch, input logic [31:0] d);
      return {rel[7:0], fd, v, ch, d};
   endfunction

   function automatic logic [127:0] ramp(input int base);
      logic [127:0] f;
      f = '0;
      for (int k = 0; k < NUM_CH; k++) f[16*k +: 16] = 16'(base + k);
      return f;
   endfunction

   // scoreboard / monitor (samples 2 time units after each rising edge) ------
   int            cyc = 0;
   int            t0  = 0;
   int            mon_rel;
   logic [EW-1:0] obs_q[$];
   logic [EW-1:0] exp_q[$];
   int            ov_q[$];
   logic          busy_hist [256];
   logic [15:0]   dp_hist   [256];

   always @(posedge clk) begin
      #2;
      cyc     = cyc + 1;
      mon_rel = cyc - t0;
      if (mon_rel >= 0 && mon_rel < 256) begin
         busy_hist[mon_rel] = busy;
         dp_hist[mon_rel]   = dp_data;
      end
      if (res_valid || frame_done)
         obs_q.push_back(mk(mon_rel, frame_done, res_valid,
                            res_valid ? res_ch : 3'd0, res_valid ? res_data : 32'h0));
      if (overflow) ov_q.push_back(mon_rel);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // driver tasks ----------------------------------------------------------
   // Called on a falling edge; rel 0 is the rising edge that samples the strobe.
   task automatic start_scn();
      obs_q.delete();
      exp_q.delete();
      ov_q.delete();
      for (int i = 0; i < 256; i++) begin
         busy_hist[i] = 1'b0;
         dp_hist[i]   = 16'h0;
      end
      t0 = cyc + 1;
   endtask

   task automatic send_frame(input logic [127:0] d, input logic [7:0] m);
      frame_valid = 1'b1;
      frame_data  = d;
      ch_mask     = m;
      @(negedge clk);
      frame_valid = 1'b0;
   endtask

`ifdef CAIL_PARAM_WR_EN
   task automatic write_coef(input logic [2:0] a, input logic [31:0] v);
      param_wr    = 1'b1;
      param_addr  = a;
      param_wdata = v;
      @(negedge clk);
      param_wr = 1'b0;
   endtask
`endif

   // expected result slots for a ramp frame (sample k = base+k) issued from rel0-11
   task automatic expect_ramp(input int base, input logic [7:0] m, input int rel0);
      for (int k = 0; k < NUM_CH; k++)
         if (m[k] || k == NUM_CH - 1)
            exp_q.push_back(mk(rel0 + k, (k == NUM_CH - 1), m[k],
                               m[k] ? 3'(k) : 3'd0, m[k] ? fval(base + k) : 32'h0));
   endtask

   task automatic compare_scn(input string name, input int exp_ov_rel);
      check({name, "_n"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < obs_q.size()) check($sformatf("%s_e%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
      check({name, "_ovn"}, 64'(ov_q.size()), (exp_ov_rel >= 0) ? 64'd1 : 64'd0);
      if (ov_q.size() > 0) check({name, "_ovrel"}, 64'(ov_q[0]), 64'(exp_ov_rel));
   endtask

   task automatic check_idle(input string name);
      check({name, "_dp_data"},  64'(dp_data),    64'h0);
      check({name, "_dp_param"}, 64'(dp_param),   64'h0);
      check({name, "_res_v"},    64'(res_valid),  64'h0);
      check({name, "_res_ch"},   64'(res_ch),     64'h0);
      check({name, "_res_data"}, 64'(res_data),   64'h0);
      check({name, "_fdone"},    64'(frame_done), 64'h0);
      check({name, "_busy"},     64'(busy),       64'h0);
      check({name, "_ovf"},      64'(overflow),   64'h0);
      check({name, "_state"},    64'(dbg_state),  64'h0);
   endtask

   // basic frame: samples 0..7, all channels enabled
   task automatic run_basic(input string name);
      start_scn();
      send_frame(ramp(0), 8'hFF);
      repeat (30) @(negedge clk);
      expect_ramp(0, 8'hFF, 11);
      compare_scn(name, -1);
      check({name, "_dp_r0"},   64'(dp_hist[0]),   64'h0);
      check({name, "_dp_r2"},   64'(dp_hist[2]),   64'h1);
      check({name, "_dp_r8"},   64'(dp_hist[8]),   64'h7);
      check({name, "_dp_r9"},   64'(dp_hist[9]),   64'h0);
      check({name, "_busy_r0"}, 64'(busy_hist[0]), 64'h1);
      check({name, "_busy_r18"},64'(busy_hist[18]),64'h1);
      check({name, "_busy_r19"},64'(busy_hist[19]),64'h0);
   endtask

   // watchdog --------------------------------------------------------------
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // main sequence -----------------------------------------------------------
   initial begin
      logic [127:0] f;
      rst         = 1'b1;
      frame_valid = 1'b0;
      frame_data  = '0;
      ch_mask     = '0;
`ifdef CAIL_PARAM_WR_EN
      param_wr    = 1'b0;
      param_addr  = '0;
      param_wdata = '0;
`endif
      repeat (3) @(negedge clk);
      check_idle("rst");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // unity coefficients, ramp frame
      run_basic("s1");

`ifdef CAIL_PARAM_WR_EN
      // coef[3] = 2.0, ch3 sample 100 -> 200.0
      write_coef(3'd3, 32'h4000_0000);
      start_scn();
      f = ramp(0);
      f[63:48] = 16'd100;
      send_frame(f, 8'hFF);
      repeat (30) @(negedge clk);
      expect_ramp(0, 8'hFF, 11);
      exp_q[3] = mk(14, 1'b0, 1'b1, 3'd3, 32'h4348_0000);
      compare_scn("s2", -1);
      write_coef(3'd3, 32'h3F80_0000);
      @(negedge clk);
`endif

      // mask 0xA5: results only on ch 0,2,5,7; frame_done in ch 7's slot
      start_scn();
      send_frame(ramp(0), 8'hA5);
      repeat (30) @(negedge clk);
      expect_ramp(0, 8'hA5, 11);
      compare_scn("s3", -1);
      check("s3_dp_masked", 64'(dp_hist[2]), 64'h0);
      check("s3_dp_ch2",    64'(dp_hist[3]), 64'h2);

      // three strobes two cycles apart: A issued, B pending then back-to-back, C dropped
      start_scn();
      send_frame(ramp(0), 8'hFF);
      @(negedge clk);
      send_frame(ramp(8), 8'hFF);
      @(negedge clk);
      send_frame({8{16'hFFFF}}, 8'hFF);
      repeat (30) @(negedge clk);
      expect_ramp(0, 8'hFF, 11);
      expect_ramp(8, 8'hFF, 19);
      compare_scn("s4", 4);
      check("s4_busy_r26", 64'(busy_hist[26]), 64'h1);
      check("s4_busy_r27", 64'(busy_hist[27]), 64'h0);

      // reset while issuing
      start_scn();
      send_frame(ramp(0), 8'hFF);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle("s5");
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check("s5_no_res", 64'(obs_q.size()), 64'h0);
      run_basic("s6");

`ifdef CAIL_PARAM_WR_EN
      // write coef[5] = 2.0 in the cycle ch5 is issued: old value used, next frame new value
      start_scn();
      send_frame(ramp(0), 8'hFF);
      repeat (5) @(negedge clk);
      write_coef(3'd5, 32'h4000_0000);
      repeat (25) @(negedge clk);
      expect_ramp(0, 8'hFF, 11);
      compare_scn("s7", -1);
      start_scn();
      send_frame(ramp(0), 8'hFF);
      repeat (30) @(negedge clk);
      expect_ramp(0, 8'hFF, 11);
      exp_q[5] = mk(16, 1'b0, 1'b1, 3'd5, 32'h4120_0000);
      compare_scn("s8", -1);
      write_coef(3'd5, 32'h3F80_0000);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
